// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter, frames paced by tx_tick.
// Build option: define UART_TX_BREAK_EN to add the BREAK state (break_i).
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   tx_tick           one-cycle pulse per bit period
//   wr_data_i/valid_i push side; wr_ready_o = !full
//   data_len_i        data bits per frame (clamped 5..DATA_W)
//   parity_en_i       append parity; parity_type_i 0=even 1=odd
//   stop_bit_num_i    0 = one stop bit, 1 = two
//   break_i           break request (UART_TX_BREAK_EN only)
//   cts_n             clear-to-send, active low, sampled at frame start
//   tx                serial line (registered)
//   busy_o            frame or break in progress
//   tx_done_o         pulse on the tick that ends the last stop bit
//   fifo_empty_o/fifo_full_o/fifo_level_o  FIFO status
module uart_tx_fifo #(
  parameter  int DATA_W     = 8,
  parameter  int FIFO_DEPTH = 16,
  localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_tick,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [3:0]        data_len_i,
  input  logic              parity_en_i,
  input  logic              parity_type_i,
  input  logic              stop_bit_num_i,
  input  logic              break_i,
  input  logic              cts_n,
  output logic              tx,
  output logic              busy_o,
  output logic              tx_done_o,
  output logic              fifo_empty_o,
  output logic              fifo_full_o,
  output logic [LVL_W-1:0]  fifo_level_o
);

  localparam int         PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [3:0] LEN_MAX = 4'(DATA_W);
  localparam logic [3:0] LEN_MIN = 4'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
`ifdef UART_TX_BREAK_EN
    , ST_BREAK
`endif
  } state_t;

  // FIFO
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [LVL_W-1:0]  count_q;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  // frame engine
  state_t            state_q;
  state_t            state_d;
  logic [3:0]        cnt_q;
  logic [3:0]        cnt_d;
  logic              stp_q;
  logic              stp_d;
  logic [DATA_W-1:0] sh_q;
  logic [DATA_W-1:0] sh_d;
  logic              tx_q;
  logic              tx_d;
  logic [3:0]        len_q;
  logic              par_en_q;
  logic              par_q;
  logic              stop2_q;
  logic              load;
  logic              done;
  logic              launch;
  logic              start_ok;

  logic [3:0]        len_c;
  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] masked;
  logic              head_par;

  assign full  = (count_q == LVL_W'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign push  = wr_valid_i && !full;
  assign pop   = load;

  assign wr_ready_o   = !full;
  assign fifo_full_o  = full;
  assign fifo_empty_o = empty;
  assign fifo_level_o = count_q;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + LVL_W'(1);
        2'b01:   count_q <= count_q - LVL_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Frame setup from the head word and live configuration
  always_comb begin
    len_c = data_len_i;
    if (data_len_i < LEN_MIN) len_c = LEN_MIN;
    if (data_len_i > LEN_MAX) len_c = LEN_MAX;
  end

  assign head = mem[rd_ptr_q];

  // Bits at or above the frame length are zeroed so the
  // parity reduction covers only transmitted bits.
  always_comb begin
    masked = '0;
    for (int i = 0; i < DATA_W; i++) begin
      masked[i] = head[i] & (i < int'(len_c));
    end
  end

  assign head_par = (^masked) ^ parity_type_i;
  assign start_ok = !empty && !cts_n;

  // The tick that ends the last stop bit doubles as the
  // launch point for the next frame, so frames stream
  // back to back with no idle bit between them.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stp_d   = stp_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    load    = 1'b0;
    done    = 1'b0;
    launch  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (tx_tick) launch = 1'b1;
      end
      ST_START: begin
        if (tx_tick) begin
          state_d = ST_DATA;
          cnt_d   = 4'd0;
          tx_d    = sh_q[0];
        end
      end
      ST_DATA: begin
        if (tx_tick) begin
          if (cnt_q == len_q - 4'd1) begin
            stp_d = 1'b0;
            if (par_en_q) begin
              state_d = ST_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
            sh_d  = sh_q >> 1;
            tx_d  = sh_q[1];
          end
        end
      end
      ST_PARITY: begin
        if (tx_tick) begin
          state_d = ST_STOP;
          stp_d   = 1'b0;
          tx_d    = 1'b1;
        end
      end
      ST_STOP: begin
        if (tx_tick) begin
          if (stop2_q && !stp_q) begin
            stp_d = 1'b1;
          end else begin
            done   = 1'b1;
            launch = 1'b1;
          end
        end
      end
`ifdef UART_TX_BREAK_EN
      ST_BREAK: begin
        if (tx_tick && !break_i) begin
          state_d = ST_IDLE;
          tx_d    = 1'b1;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    if (launch) begin
      state_d = ST_IDLE;
      tx_d    = 1'b1;
      if (start_ok) begin
        state_d = ST_START;
        tx_d    = 1'b0;
        load    = 1'b1;
        sh_d    = masked;
      end
`ifdef UART_TX_BREAK_EN
      // break wins over a pending word; nothing is popped
      if (break_i) begin
        state_d = ST_BREAK;
        tx_d    = 1'b0;
        load    = 1'b0;
        sh_d    = sh_q;
      end
`endif
    end
  end

`ifndef UART_TX_BREAK_EN
  logic unused_break;
  assign unused_break = break_i;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      stp_q    <= 1'b0;
      sh_q     <= '0;
      tx_q     <= 1'b1;
      len_q    <= LEN_MAX;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
      stop2_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stp_q   <= stp_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
      if (load) begin
        len_q    <= len_c;
        par_en_q <= parity_en_i;
        par_q    <= head_par;
        stop2_q  <= stop_bit_num_i;
      end
    end
  end

  assign tx        = tx_q;
  assign busy_o    = (state_q != ST_IDLE);
  assign tx_done_o = done;

endmodule
